// File: rtl/vip_dvp_tx.sv
// DVP transmitter: generates href/hsync/vsync timing and streams valid/ready pixels through the active window.
// Optional build macro VIP_DVP_TX_PATTERN_EN adds pattern_en and an internal test-pattern source.
module vip_dvp_tx #(
    parameter int BITS    = 8,
    parameter int H_FRONT = 5,
    parameter int H_PULSE = 10,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 1920,
    parameter int V_FRONT = 6,
    parameter int V_PULSE = 20,
    parameter int V_BACK  = 3,
    parameter int V_DISP  = 1080,
    parameter int H_POL   = 0,
    parameter int V_POL   = 1
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*BITS-1:0] in_data,
    output logic              out_href,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic [BITS-1:0]   out_data_r,
    output logic [BITS-1:0]   out_data_g,
    output logic [BITS-1:0]   out_data_b,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
`ifdef VIP_DVP_TX_PATTERN_EN
    ,
    input  logic              pattern_en
`endif
);

    localparam int H_TOTAL = H_PULSE + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_PULSE + V_BACK + V_DISP + V_FRONT;

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_E  = 12'(H_PULSE);
    localparam logic [11:0] V_SYNC_E  = 12'(V_PULSE);
    localparam logic [11:0] H_ACT_B   = 12'(H_PULSE + H_BACK);
    localparam logic [11:0] V_ACT_B   = 12'(V_PULSE + V_BACK);
    localparam logic [11:0] H_ACT_E   = 12'(H_PULSE + H_BACK + H_DISP);
    localparam logic [11:0] V_ACT_E   = 12'(V_PULSE + V_BACK + V_DISP);
    localparam logic        HS_ACT    = 1'(H_POL);
    localparam logic        VS_ACT    = 1'(V_POL);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t            state_q, state_d;
    logic [11:0]       h_q, h_d, v_q, v_d;
    logic              href_q, hsync_q, vsync_q, fs_q, uf_q;
    logic [3*BITS-1:0] data_q, data_d;
    logic              active_w, hsync_w, vsync_w, fs_w, uf_d;
    logic              frame_end_w, pat_w;

`ifdef VIP_DVP_TX_PATTERN_EN
    logic pat_q, pat_d;

    function automatic logic [3*BITS-1:0] pattern_px(input logic [11:0] h, input logic [11:0] v);
        logic [11:0] px, ln;
        px = h - H_ACT_B;
        ln = v - V_ACT_B;
        return {px[BITS-1:0], ln[BITS-1:0], px[BITS-1:0] ^ ln[BITS-1:0]};
    endfunction
`endif

    assign frame_end_w = (h_q == H_LAST) && (v_q == V_LAST);

    // State and counter register
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Next state; STOP lets the current frame finish before going idle
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = STOP;
            STOP:    if (enable) state_d = RUN;
                     else if (frame_end_w) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
        end else begin
            h_d = h_q + 12'd1;
        end
    end

`ifdef VIP_DVP_TX_PATTERN_EN
    assign pat_w = pat_q;
`else
    assign pat_w = 1'b0;
`endif

    // Output decode from current state and counters
    always_comb begin
        active_w = (state_q != IDLE) && (h_q >= H_ACT_B) && (h_q < H_ACT_E)
                   && (v_q >= V_ACT_B) && (v_q < V_ACT_E);
        hsync_w  = ((state_q != IDLE) && (h_q < H_SYNC_E)) ? HS_ACT : ~HS_ACT;
        vsync_w  = ((state_q != IDLE) && (v_q < V_SYNC_E)) ? VS_ACT : ~VS_ACT;
        fs_w     = (state_q != IDLE) && (h_q == 12'd0) && (v_q == 12'd0);
        in_ready = active_w && !pat_w;
        uf_d     = uf_q;
        if (underflow_clr)
            uf_d = 1'b0;
        else if (in_ready && !in_valid)
            uf_d = 1'b1;
        data_d = '0;
        if (active_w) begin
`ifdef VIP_DVP_TX_PATTERN_EN
            if (pat_q)
                data_d = pattern_px(h_q, v_q);
            else if (in_valid)
                data_d = in_data;
`else
            if (in_valid)
                data_d = in_data;
`endif
        end
    end

`ifdef VIP_DVP_TX_PATTERN_EN
    // Pattern selection only changes on a frame boundary
    always_comb begin
        pat_d = pat_q;
        if (fs_w)
            pat_d = pattern_en;
    end

    always_ff @(posedge pclk) begin
        if (rst) pat_q <= 1'b0;
        else     pat_q <= pat_d;
    end
`endif

    // Registered outputs, one cycle behind the counters
    always_ff @(posedge pclk) begin
        if (rst) begin
            href_q  <= 1'b0;
            hsync_q <= ~HS_ACT;
            vsync_q <= ~VS_ACT;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            href_q  <= active_w;
            hsync_q <= hsync_w;
            vsync_q <= vsync_w;
            fs_q    <= fs_w;
            uf_q    <= uf_d;
            data_q  <= data_d;
        end
    end

    assign out_href    = href_q;
    assign out_hsync   = hsync_q;
    assign out_vsync   = vsync_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;
    assign out_data_r  = data_q[3*BITS-1:2*BITS];
    assign out_data_g  = data_q[2*BITS-1:BITS];
    assign out_data_b  = data_q[BITS-1:0];

endmodule

// File: tb/tb_vip_dvp_tx.sv
// Directed bench for vip_dvp_tx on a small 14x8 frame; pattern checks only when VIP_DVP_TX_PATTERN_EN is defined.
module tb_vip_dvp_tx;
    localparam int BITS = 8;

    logic        pclk = 1'b0;
    logic        rst, enable, in_valid, in_ready, underflow_clr;
    logic [23:0] in_data;
    logic        out_href, out_hsync, out_vsync, frame_start, underflow;
    logic [7:0]  out_data_r, out_data_g, out_data_b;
`ifdef VIP_DVP_TX_PATTERN_EN
    logic        pattern_en;
`endif

    vip_dvp_tx #(
        .BITS(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(1), .H_DISP(8),
        .V_FRONT(1), .V_PULSE(2), .V_BACK(1), .V_DISP(4), .H_POL(0), .V_POL(1)
    ) dut (
        .pclk(pclk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_href(out_href), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_data_r(out_data_r), .out_data_g(out_data_g), .out_data_b(out_data_b),
        .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
`ifdef VIP_DVP_TX_PATTERN_EN
        , .pattern_en(pattern_en)
`endif
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int src_n  = 0;

    typedef struct {
        int   k;
        logic rdy;
        logic href;
        logic hs;
        logic vs;
        logic fs;
    } vec_t;

    vec_t vt[17];
    logic obs_rdy [0:119];
    logic obs_href[0:119];
    logic obs_hs  [0:119];
    logic obs_vs  [0:119];
    logic obs_fs  [0:119];

    function automatic logic [23:0] mkpix(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {b, ~b, b ^ 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample acceptance, clock, then update the incrementing source
    task automatic tick();
        logic acc;
        acc = in_ready && in_valid;
        @(posedge pclk);
        @(negedge pclk);
        if (acc) src_n++;
        in_data = mkpix(src_n);
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        int m, hs_lo, vs_hi, hr, n0;
        logic [23:0] exp_px;

        rst = 1'b1; enable = 1'b0; in_valid = 1'b1; underflow_clr = 1'b0;
        in_data = mkpix(0);
`ifdef VIP_DVP_TX_PATTERN_EN
        pattern_en = 1'b0;
`endif
        vt[0]  = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[2]  = '{3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{4,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{28,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{29,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{45,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{46,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{47,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{53,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[10] = '{54,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{55,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[12] = '{95,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[13] = '{96,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[14] = '{97,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[15] = '{112, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[16] = '{113, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        chk("rst_href", 32'(out_href), 32'd0);
        chk("rst_hsync", 32'(out_hsync), 32'd1);
        chk("rst_vsync", 32'(out_vsync), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        chk("rst_data", 32'({out_data_r, out_data_g, out_data_b}), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_hsync", 32'(out_hsync), 32'd1);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // First frame: record every cycle from RUN entry
        enable = 1'b1;
        tick();
        cyc = 0;
        m = 0;
        for (int k = 0; k <= 113; k++) begin
            obs_rdy[k] = in_ready; obs_href[k] = out_href; obs_hs[k] = out_hsync;
            obs_vs[k] = out_vsync; obs_fs[k] = frame_start;
            if (k <= 111 && out_href) begin
                chk($sformatf("px%0d", m), 32'({out_data_r, out_data_g, out_data_b}), 32'(mkpix(m)));
                m++;
            end
            tick();
        end
        foreach (vt[i]) begin
            chk($sformatf("rdy_k%0d", vt[i].k), 32'(obs_rdy[vt[i].k]), 32'(vt[i].rdy));
            chk($sformatf("href_k%0d", vt[i].k), 32'(obs_href[vt[i].k]), 32'(vt[i].href));
            chk($sformatf("hs_k%0d", vt[i].k), 32'(obs_hs[vt[i].k]), 32'(vt[i].hs));
            chk($sformatf("vs_k%0d", vt[i].k), 32'(obs_vs[vt[i].k]), 32'(vt[i].vs));
            chk($sformatf("fs_k%0d", vt[i].k), 32'(obs_fs[vt[i].k]), 32'(vt[i].fs));
        end
        hs_lo = 0; vs_hi = 0; hr = 0;
        for (int k = 1; k <= 112; k++) begin
            if (!obs_hs[k]) hs_lo++;
            if (obs_vs[k]) vs_hi++;
            if (obs_href[k]) hr++;
        end
        chk("hsync_low_cycles", 32'(hs_lo), 32'd24);
        chk("vsync_high_cycles", 32'(vs_hi), 32'd28);
        chk("href_cycles", 32'(hr), 32'd32);
        chk("pixels_seen", 32'(m), 32'd32);
        chk("no_uf_frame1", 32'(underflow), 32'd0);

        // Underflow: third pixel of active line 2 in frame 2
        run_to(188);
        chk("uf_pre_data", 32'({out_data_r, out_data_g, out_data_b}), 32'(mkpix(49)));
        chk("uf_pre_flag", 32'(underflow), 32'd0);
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        chk("uf_gap_href", 32'(out_href), 32'd1);
        chk("uf_gap_data", 32'({out_data_r, out_data_g, out_data_b}), 32'd0);
        chk("uf_set", 32'(underflow), 32'd1);
        tick();
        chk("uf_next_data", 32'({out_data_r, out_data_g, out_data_b}), 32'(mkpix(50)));
        chk("uf_sticky", 32'(underflow), 32'd1);
        run_to(191);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk("uf_cleared", 32'(underflow), 32'd0);
        run_to(200);
        in_valid = 1'b0; underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk("uf_clr_prio", 32'(underflow), 32'd0);
        chk("uf_clr_href", 32'(out_href), 32'd1);
        tick();
        in_valid = 1'b1;
        chk("uf_reset_after", 32'(underflow), 32'd1);

        // Stop mid-frame: frame 3 must still complete
        run_to(224);
        n0 = src_n;
        hr = 0;
        while (cyc <= 336) begin
            if (cyc == 284) enable = 1'b0;
            if (cyc >= 225 && out_href) hr++;
            tick();
        end
        chk("stop_href_cycles", 32'(hr), 32'd32);
        chk("stop_pixels", 32'(src_n - n0), 32'd32);
        chk("stop_no_fs", 32'(frame_start), 32'd0);
        run_to(340);
        chk("stop_idle_ready", 32'(in_ready), 32'd0);
        chk("stop_idle_hsync", 32'(out_hsync), 32'd1);
        chk("stop_idle_vsync", 32'(out_vsync), 32'd0);
        chk("stop_idle_href", 32'(out_href), 32'd0);
        enable = 1'b1;
        tick();
        cyc = 0;
        tick();
        chk("restart_fs", 32'(frame_start), 32'd1);

        // Reset while href is high
        run_to(50);
        chk("pre_rst_href", 32'(out_href), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_href", 32'(out_href), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_hsync", 32'(out_hsync), 32'd1);
        chk("midrst_vsync", 32'(out_vsync), 32'd0);
        chk("midrst_data", 32'({out_data_r, out_data_g, out_data_b}), 32'd0);
        chk("midrst_uf", 32'(underflow), 32'd0);
        tick();
        cyc = 0;
        tick();
        chk("postrst_fs", 32'(frame_start), 32'd1);
        run_to(45);
        chk("postrst_rdy45", 32'(in_ready), 32'd0);
        tick();
        chk("postrst_rdy46", 32'(in_ready), 32'd1);

`ifdef VIP_DVP_TX_PATTERN_EN
        // Pattern request mid-frame must wait for the next frame start
        pattern_en = 1'b1;
        exp_px = in_data;
        tick();
        chk("pat_deferred", 32'({out_data_r, out_data_g, out_data_b}), 32'(exp_px));
        run_to(113);
        in_valid = 1'b0;
        run_to(177);
        chk("pat_ready", 32'(in_ready), 32'd0);
        tick();
        chk("pat_href", 32'(out_href), 32'd1);
        chk("pat_r", 32'(out_data_r), 32'd5);
        chk("pat_g", 32'(out_data_g), 32'd1);
        chk("pat_b", 32'(out_data_b), 32'd4);
        chk("pat_no_uf", 32'(underflow), 32'd0);
`else
        exp_px = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
